// File: rtl/codec_pkg.sv
// Shared constants and types for the line decoder/encoder family.
package codec_pkg;

    localparam logic [1:0] ENA_ACTIVE = 2'b10;
    localparam int         LINES      = 8;
    localparam int         IDX_W      = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             none;
        logic             multi;
    } enc_result_t;

    function automatic logic is_enabled(input logic [1:0] ena);
        return ena == ENA_ACTIVE;
    endfunction

endpackage

// File: rtl/encoder_8to3_if.sv
// Handshake bundle between a line-vector producer, the encoder and the index consumer.
interface encoder_8to3_if
    import codec_pkg::*;
#(
    parameter int ERRCNT_W = 8
);
    logic [1:0]          iEna;
    logic [LINES-1:0]    iData;
    logic                iValid;
    logic                oReady;
    logic [IDX_W-1:0]    oData;
    logic                oNone;
    logic                oMulti;
    logic                oValid;
    logic                iReady;
    logic [ERRCNT_W-1:0] oErrCnt;

    modport slave (
        input  iEna, iData, iValid, iReady,
        output oReady, oData, oNone, oMulti, oValid, oErrCnt
    );

    modport master (
        output iEna, iData, iValid, iReady,
        input  oReady, oData, oNone, oMulti, oValid, oErrCnt
    );
endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-line priority encoder with empty and multi-hot flags.
module prio_enc8
    import codec_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [LINES-1:0] iData,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             multi
);

    always_comb begin
        // NOTE: assign every always_comb output before any branch so no path can infer a latch.
        idx = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < LINES; i++) begin
                if (iData[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = LINES - 1; i >= 0; i--) begin
                if (iData[i]) idx = IDX_W'(i);
            end
        end
    end

    assign none  = (iData == '0);
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi = ((iData & (iData - LINES'(1))) != '0);

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with a one-entry valid/ready output stage
// and a saturating count of multi-hot inputs.
module encoder_8to3
    import codec_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1,
    parameter int ERRCNT_W  = 8
) (
    input  logic           iClk,
    input  logic           iRst_n,
    encoder_8to3_if.slave  bus
);

    state_e              state_q, state_d;
    enc_result_t         res_q, res_d, enc;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                en, ready, push, pop;

    prio_enc8 #(.PRIO_HIGH(PRIO_HIGH)) u_prio_enc8 (
        .iData (bus.iData),
        .idx   (enc.idx),
        .none  (enc.none),
        .multi (enc.multi)
    );

    // Ready ignores iValid so an upstream may wait on it without a combinational loop.
    assign en    = is_enabled(bus.iEna);
    assign ready = en && ((state_q == ST_EMPTY) || bus.iReady);
    assign push  = bus.iValid && ready;
    assign pop   = (state_q == ST_FULL) && bus.iReady;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        errcnt_d = errcnt_q;
        if (push) begin
            state_d = ST_FULL;
            res_d   = enc;
            if (enc.multi && (errcnt_q != '1)) errcnt_d = errcnt_q + ERRCNT_W'(1);
        end else if (pop) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge iClk) begin
        // NOTE: reset is synchronous (sampled here, not in the sensitivity list) and all state uses <=.
        if (!iRst_n) begin
            state_q  <= ST_EMPTY;
            res_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.oReady  = ready;
    assign bus.oValid  = (state_q == ST_FULL);
    assign bus.oData   = res_q.idx;
    assign bus.oNone   = res_q.none;
    assign bus.oMulti  = res_q.multi;
    assign bus.oErrCnt = errcnt_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Bench for encoder_8to3: a highest-priority/8-bit-counter instance and a
// lowest-priority/2-bit-counter instance share one directed stimulus stream.
module tb_encoder_8to3;
    import codec_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ena;
    logic [7:0] din;
    logic       vld;
    logic       rdy;
    logic       chk_on = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    encoder_8to3_if #(.ERRCNT_W(8)) bus_hi ();
    encoder_8to3_if #(.ERRCNT_W(2)) bus_lo ();

    assign bus_hi.iEna   = ena;
    assign bus_hi.iData  = din;
    assign bus_hi.iValid = vld;
    assign bus_hi.iReady = rdy;
    assign bus_lo.iEna   = ena;
    assign bus_lo.iData  = din;
    assign bus_lo.iValid = vld;
    assign bus_lo.iReady = rdy;

    encoder_8to3 #(.PRIO_HIGH(1'b1), .ERRCNT_W(8)) dut_hi (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus_hi)
    );

    encoder_8to3 #(.PRIO_HIGH(1'b0), .ERRCNT_W(2)) dut_lo (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus_lo)
    );

    // Reference model: index 0 = dut_hi, index 1 = dut_lo.
    bit m_valid [2];
    int m_idx   [2];
    bit m_none  [2];
    bit m_multi [2];
    int m_cnt   [2];
    int cnt_max [2] = '{255, 3};
    bit prio_hi [2] = '{1'b1, 1'b0};

    // floor(log2) of the value, or of its lowest set bit for low priority.
    function automatic int ref_index(input logic [7:0] d, input bit hi);
        int v;
        int n;
        if (d == 8'h00) return 0;
        v = hi ? int'(d) : int'(d & (~d + 8'd1));
        n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    function automatic bit model_ready(input int k);
        return (ena == 2'b10) && (!m_valid[k] || rdy);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_valid[k] = 1'b0;
                m_idx[k]   = 0;
                m_none[k]  = 1'b0;
                m_multi[k] = 1'b0;
                m_cnt[k]   = 0;
            end else if (vld && model_ready(k)) begin
                m_valid[k] = 1'b1;
                m_idx[k]   = ref_index(din, prio_hi[k]);
                m_none[k]  = (din == 8'h00);
                m_multi[k] = ($countones(din) > 1);
                if (m_multi[k] && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("hi.ready", bus_hi.oReady,  model_ready(0));
            check("hi.valid", bus_hi.oValid,  m_valid[0]);
            check("hi.errcnt", bus_hi.oErrCnt, m_cnt[0]);
            check("lo.ready", bus_lo.oReady,  model_ready(1));
            check("lo.valid", bus_lo.oValid,  m_valid[1]);
            check("lo.errcnt", bus_lo.oErrCnt, m_cnt[1]);
            if (m_valid[0]) begin
                check("hi.data",  bus_hi.oData,  m_idx[0]);
                check("hi.none",  bus_hi.oNone,  m_none[0]);
                check("hi.multi", bus_hi.oMulti, m_multi[0]);
            end
            if (m_valid[1]) begin
                check("lo.data",  bus_lo.oData,  m_idx[1]);
                check("lo.none",  bus_lo.oNone,  m_none[1]);
                check("lo.multi", bus_lo.oMulti, m_multi[1]);
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] e, input logic [7:0] d,
                        input logic v, input logic rd);
        rst_n = r;
        ena   = e;
        din   = d;
        vld   = v;
        rdy   = rd;
        @(posedge clk);
        #1;
    endtask

    int sat_exp [5] = '{2, 3, 3, 3, 3};

    initial begin
        // Reset state.
        step(1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
        step(1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
        chk_on = 1'b1;
        check("rst.valid",  bus_hi.oValid,  0);
        check("rst.data",   bus_hi.oData,   0);
        check("rst.none",   bus_hi.oNone,   0);
        check("rst.multi",  bus_hi.oMulti,  0);
        check("rst.errcnt", bus_hi.oErrCnt, 0);
        check("rst.lo.data", bus_lo.oData,  0);

        // Wrong enable code: no capture, not ready.
        step(1'b1, 2'b11, 8'h04, 1'b1, 1'b1);
        check("dis.valid", bus_hi.oValid, 0);
        check("dis.ready", bus_hi.oReady, 0);

        step(1'b1, 2'b10, 8'h04, 1'b1, 1'b1);
        check("en.valid", bus_hi.oValid, 1);
        check("en.data",  bus_hi.oData,  2);
        check("model.en.data", m_idx[0], 2);

        // One-hot sweep, back to back; din is the decoder image of i.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            one = 8'd1 << i;
            step(1'b1, 2'b10, one, 1'b1, 1'b1);
            check("sweep.hi.data", bus_hi.oData, i);
            check("sweep.lo.data", bus_lo.oData, i);
            check("sweep.valid",   bus_hi.oValid, 1);
        end
        check("sweep.errcnt", bus_hi.oErrCnt, 0);

        // Multi-hot: priority direction matters.
        step(1'b1, 2'b10, 8'b1001_0010, 1'b1, 1'b1);
        check("multi.hi.data",  bus_hi.oData,   7);
        check("multi.lo.data",  bus_lo.oData,   1);
        check("multi.flag",     bus_hi.oMulti,  1);
        check("multi.hi.cnt",   bus_hi.oErrCnt, 1);
        check("multi.lo.cnt",   bus_lo.oErrCnt, 1);
        check("model.multi.lo", m_idx[1],       1);

        // Empty vector.
        step(1'b1, 2'b10, 8'h00, 1'b1, 1'b1);
        check("none.data",  bus_hi.oData,  0);
        check("none.flag",  bus_hi.oNone,  1);
        check("none.multi", bus_hi.oMulti, 0);

        // Backpressure: drain, push 5, then hold with ignored input.
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
        step(1'b1, 2'b10, 8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b10, 8'hFF, 1'b1, 1'b0);
            check("bp.data",  bus_hi.oData,  5);
            check("bp.valid", bus_hi.oValid, 1);
            check("bp.ready", bus_hi.oReady, 0);
        end
        check("bp.errcnt", bus_hi.oErrCnt, 1);
        step(1'b1, 2'b10, 8'h08, 1'b1, 1'b1);
        check("bp.next.data",  bus_hi.oData,  3);
        check("bp.next.valid", bus_hi.oValid, 1);

        // Disabled while full: held, then still poppable.
        step(1'b1, 2'b00, 8'h81, 1'b1, 1'b0);
        check("off.hold.data", bus_hi.oData,  3);
        check("off.ready",     bus_hi.oReady, 0);
        step(1'b1, 2'b00, 8'h81, 1'b1, 1'b1);
        check("off.pop.valid", bus_hi.oValid,  0);
        check("off.errcnt",    bus_hi.oErrCnt, 1);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b10, 8'hC3, 1'b1, 1'b1);
            check("sat.lo.cnt", bus_lo.oErrCnt, sat_exp[i]);
        end
        check("sat.hi.cnt", bus_hi.oErrCnt, 6);

        // Reset mid-operation beats a simultaneous push and pop.
        step(1'b1, 2'b10, 8'h40, 1'b1, 1'b1);
        check("pre.rst.data", bus_hi.oData, 6);
        step(1'b0, 2'b10, 8'h01, 1'b1, 1'b1);
        check("mid.rst.valid",  bus_hi.oValid,  0);
        check("mid.rst.errcnt", bus_hi.oErrCnt, 0);
        check("mid.rst.data",   bus_hi.oData,   0);
        check("mid.rst.lo.cnt", bus_lo.oErrCnt, 0);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
        check("post.rst.valid", bus_hi.oValid, 0);
        step(1'b1, 2'b10, 8'h02, 1'b1, 1'b1);
        check("post.rst.data", bus_hi.oData, 1);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/encoder_8to3.md
# encoder_8to3

Registered 8-to-3 priority encoder with a valid/ready handshake on both sides. It is the inverse of the team's 3-to-8 decoder and uses the same 2-bit enable convention. It converts a one-hot (or multi-hot) 8-bit line vector back into a 3-bit index, flags empty and multi-hot inputs, and counts multi-hot violations. It closes the loop in decoder→encoder round-trip checks and lets the decoder's outputs be consumed as indices downstream.

## Interface
- Parameters:
- PRIO_HIGH, 1, 1 = highest set bit wins; 0 = lowest set bit wins
- ERRCNT_W, 8, width of the saturating multi-hot error counter
- Ports:
- iClk  input  1  clock; all state updates on the rising edge
- iRst_n  input  1  synchronous, active-low reset
- iEna  input  2  enable pair; block is enabled only when iEna == 2'b10 (G1=1, G2=0), same code as the decoder
- iData  input  8  line vector to encode
- iValid  input  1  iData is valid this cycle
- oReady  output  1  block can accept iData this cycle
- oData  output  3  encoded index
- oNone  output  1  accepted vector was all-zero; oData = 3'b000
- oMulti  output  1  accepted vector had more than one bit set
- oValid  output  1  oData/oNone/oMulti hold a result
- iReady  input  1  downstream consumes result this cycle
- oErrCnt  output  ERRCNT_W  count of accepted multi-hot vectors, saturating at all-ones

## Operation
- Single-entry output register with two states:
- EMPTY: oValid=0.
- FULL: oValid=1, result held stable.
- en = (iEna == 2'b10). oReady = en && (EMPTY || iReady). This is combinational and has no dependence on iValid.
- push = iValid && oReady. pop = oValid && iReady.
- EMPTY + push → FULL, result captured.
- FULL + pop, no push → EMPTY.
- FULL + pop + push → FULL, new result replaces the old one in the same edge. This allows full throughput.
- FULL, no pop → held. This applies even if en drops.
- Disabled (en=0):
  - oReady=0 and no capture.
  - A held result stays valid and can still be popped.
  - oErrCnt is frozen.
- Encoding rules:
  - PRIO_HIGH=1: oData = index of the highest set bit.
  - PRIO_HIGH=0: oData = index of the lowest set bit.
  - iData == 0: oData=0, oNone=1, oMulti=0.
  - Popcount ≥ 2: oMulti=1, oNone=0.
- oErrCnt increments by 1 on each push with multi-hot iData. It holds at 2^ERRCNT_W−1 and never wraps.
- While EMPTY, oData/oNone/oMulti keep their last values. They are don't-care when oValid=0, but must not be X after reset.

## Timing
- Latency: a push at edge N gives oValid=1 with the result visible after edge N (one cycle).
- Throughput: one result per cycle while en and iReady are held high.
- Reset, sampled at a rising edge with iRst_n=0:
  - State → EMPTY; oValid=0, oData=3'b000, oNone=0, oMulti=0, oErrCnt=0.
  - Reset takes priority over a simultaneous push or pop.
  - A held result is discarded and is not delivered.
- First push is possible on the first edge with iRst_n=1 (oReady is valid combinationally once reset is released).
- iData/iValid are sampled only on push edges. Changes at other times have no effect.

## Structure
- Shared package `codec_pkg`, also used by the decoder:
  - ENA_ACTIVE = 2'b10
  - LINES = 8
  - IDX_W = 3
- Sub-module `prio_enc8`, purely combinational:
  - Inputs: iData[7:0], and PRIO_HIGH as a parameter.
  - Outputs: idx[2:0], none, multi.
  - Reused by any future wider encoders.
- Top level holds:
  - the FSM bit (EMPTY/FULL)
  - the result register
  - the saturating counter

## Test plan
- Reset then en: iEna=2'b11 with iValid=1 → oReady=0 and no capture. Switch iEna to 2'b10 and send iData=8'b0000_0100 → oValid=1, oData=3'd2 one cycle later.
- Sweep with iReady=1: send 8'h01, 02, 04 … 80 back-to-back → oData 0..7 on consecutive cycles, oNone=oMulti=0, oErrCnt=0. Loopback through the decoder for iData 0..7 returns the same index.
- Multi-hot and empty:
  - 8'b1001_0010 → oData=7 with PRIO_HIGH=1, oData=1 with PRIO_HIGH=0; oMulti=1 and oErrCnt=1 in both cases.
  - 8'h00 → oData=0, oNone=1.
- Backpressure: hold iReady=0 after one push → oReady=0, and result 3'd5 is held across 5 cycles. Raise iReady and push 8'h08 in the same cycle → next result is 3'd3 with no bubble.
- Saturation: with ERRCNT_W=2, push 5 multi-hot vectors → oErrCnt = 3, 3 (saturated, no wrap).
- Reset mid-operation: FULL with oData=6, drive iRst_n=0 for 1 cycle concurrently with iReady=1 and a push → oValid=0, oErrCnt=0, and neither the old nor the new result appears.
